// File: rtl/msx_slot_pkg.sv
// Shared definitions for the MSX slot I/O bridge: FSM state encoding,
// I/O port offsets within the decoded four-port window, and a decode helper.
package msx_slot_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_REQ    = 2'd1;
    localparam state_t ST_RDWAIT = 2'd2;
    localparam state_t ST_HOLD   = 2'd3;

    // Port offsets inside the four-port window (slot_a[1:0])
    localparam logic [1:0] PORT_VRAM_DATA = 2'd0;
    localparam logic [1:0] PORT_CONTROL   = 2'd1;
    localparam logic [1:0] PORT_PALETTE   = 2'd2;
    localparam logic [1:0] PORT_INDIRECT  = 2'd3;

    // True when an address falls into the four-port window starting at base
    function automatic logic port_match(input logic [7:0] addr, input logic [7:0] base);
        return addr[7:2] == base[7:2];
    endfunction

endpackage

// File: rtl/msx_sync2.sv
// Two-flop synchroniser for an active-low asynchronous strobe.
// Resets to 1 so the strobe reads as inactive while the block is in reset.
module msx_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/msx_slot_io_bridge.sv
// MSX cartridge-slot I/O bridge: decodes four I/O ports at IO_BASE,
// turns each host IN/OUT into a single valid/ready request to the VDP core
// and returns read data to the slot.
// Build option: define MSX_SLOT_WAIT_EN to stall the host with slot_wait for
// the duration of each access; otherwise slot_wait only follows init_busy
// and accesses arriving while busy are dropped with an overrun pulse.
module msx_slot_io_bridge
    import msx_slot_pkg::*;
#(
    parameter logic [7:0] IO_BASE = 8'h88
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] slot_a,
    input  logic       slot_iorq_n,
    input  logic       slot_rd_n,
    input  logic       slot_wr_n,
    input  logic [7:0] slot_d_in,
    output logic [7:0] slot_d_out,
    output logic       slot_data_dir,
    output logic       slot_wait,
    input  logic       init_busy,
    output logic [1:0] bus_address,
    output logic       bus_write,
    output logic [7:0] bus_wdata,
    output logic       bus_valid,
    input  logic       bus_ready,
    input  logic [7:0] bus_rdata,
    input  logic       bus_rdata_en,
    output logic       overrun
);

    // ---------------------------------------------------------------
    // Strobe synchronisation: [2]=iorq_n, [1]=rd_n, [0]=wr_n
    // ---------------------------------------------------------------
    logic [2:0] strobe_raw;
    logic [2:0] strobe_sync;

    assign strobe_raw = {slot_iorq_n, slot_rd_n, slot_wr_n};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            msx_sync2 u_sync (
                .clk     (clk),
                .reset_n (reset_n),
                .d       (strobe_raw[gi]),
                .q       (strobe_sync[gi])
            );
        end
    endgenerate

    logic iorq_s_n;
    logic rd_s_n;
    logic wr_s_n;

    assign iorq_s_n = strobe_sync[2];
    assign rd_s_n   = strobe_sync[1];
    assign wr_s_n   = strobe_sync[0];

    // ---------------------------------------------------------------
    // Access detection and decode
    // ---------------------------------------------------------------
    state_t     state_reg, state_next;
    logic       cond_prev_reg;
    logic       access_cond;
    logic       access_detect;
    logic       access_hit;
    logic       accept;
    logic       drop;

    // Rising edge of "I/O cycle in progress", qualified by the port window
    always_comb begin
        access_cond   = !iorq_s_n && (!rd_s_n || !wr_s_n);
        access_detect = access_cond && !cond_prev_reg;
        access_hit    = access_detect && port_match(slot_a, IO_BASE);
        accept        = access_hit && (state_reg == ST_IDLE);
        drop          = access_hit && (state_reg != ST_IDLE);
    end

    // Remember last cycle's access condition for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cond_prev_reg <= 1'b0;
        end else begin
            cond_prev_reg <= access_cond;
        end
    end

    // ---------------------------------------------------------------
    // Request FSM
    // ---------------------------------------------------------------
    logic       valid_reg, valid_next;
    logic       write_reg, write_next;
    logic [1:0] addr_reg, addr_next;
    logic [7:0] wdata_reg, wdata_next;
    logic [7:0] dout_reg, dout_next;
    logic       dir_reg, dir_next;
    logic       overrun_reg, overrun_next;

    // Next-state and output-register computation
    always_comb begin
        state_next   = state_reg;
        valid_next   = valid_reg;
        write_next   = write_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        dout_next    = dout_reg;
        dir_next     = dir_reg;
        overrun_next = drop;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_REQ;
                    valid_next = 1'b1;
                    addr_next  = slot_a[1:0];
                    // A write strobe wins when both strobes are low
                    write_next = !wr_s_n;
                    wdata_next = slot_d_in;
                end
            end
            ST_REQ: begin
                if (bus_ready) begin
                    valid_next = 1'b0;
                    if (write_reg) begin
                        state_next = ST_HOLD;
                    end else if (bus_rdata_en) begin
                        // Zero-latency read return alongside the accept
                        dout_next  = bus_rdata;
                        dir_next   = 1'b1;
                        state_next = ST_HOLD;
                    end else begin
                        state_next = ST_RDWAIT;
                    end
                end
            end
            ST_RDWAIT: begin
                if (bus_rdata_en) begin
                    dout_next  = bus_rdata;
                    dir_next   = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Keep driving read data until the host ends the I/O cycle
                if (iorq_s_n) begin
                    dir_next   = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                valid_next = 1'b0;
                dir_next   = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            valid_reg   <= 1'b0;
            write_reg   <= 1'b0;
            addr_reg    <= 2'd0;
            wdata_reg   <= 8'd0;
            dout_reg    <= 8'd0;
            dir_reg     <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            valid_reg   <= valid_next;
            write_reg   <= write_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            dout_reg    <= dout_next;
            dir_reg     <= dir_next;
            overrun_reg <= overrun_next;
        end
    end

    assign bus_valid     = valid_reg;
    assign bus_write     = write_reg;
    assign bus_address   = addr_reg;
    assign bus_wdata     = wdata_reg;
    assign slot_d_out    = dout_reg;
    assign slot_data_dir = dir_reg;
    assign overrun       = overrun_reg;

    // ---------------------------------------------------------------
    // Host wait request
    // ---------------------------------------------------------------
`ifdef MSX_SLOT_WAIT_EN
    // Stall from the accept cycle until the write is taken or read data lands
    assign slot_wait = init_busy || accept ||
                       (state_reg == ST_REQ) || (state_reg == ST_RDWAIT);
`else
    assign slot_wait = init_busy;
`endif

endmodule

// File: doc/msx_slot_io_bridge.md
MSX_SLOT_IO_BRIDGE -- requirements
Module: msx_slot_io_bridge

Interface
REQ-001 SHALL have parameter IO_BASE, default 8'h88, meaning the I/O base port; bits [1:0] are ignored and four ports are decoded.
REQ-002 SHALL have port clk, input, 1, system clock; the only clock in the block.
REQ-003 SHALL have port reset_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port slot_a, input, 8, slot address bus (low byte).
REQ-005 SHALL have ports slot_iorq_n / slot_rd_n / slot_wr_n, input, 1 each, asynchronous slot strobes.
REQ-006 SHALL have port slot_d_in, input, 8, slot data from the host.
REQ-007 SHALL have port slot_d_out, output, 8, read data driven to the slot.
REQ-008 SHALL have port slot_data_dir, output, 1, direction flag: 1 means the cartridge drives slot_d, 0 means the host drives it.
REQ-009 SHALL have port slot_wait, output, 1, wait request to the host.
REQ-010 SHALL have port init_busy, input, 1, core still initialising (SDRAM); forces wait.
REQ-011 SHALL have ports bus_address (output, 2), bus_write (output, 1), bus_wdata (output, 8) and bus_valid (output, 1), forming the request to the VDP core.
REQ-012 SHALL have ports bus_ready (input, 1), bus_rdata (input, 8) and bus_rdata_en (input, 1), the core's accept and read-return signals.
REQ-013 SHALL have port overrun, output, 1, one-cycle pulse when an access is dropped.

Function
REQ-014 SHALL pass slot_iorq_n, slot_rd_n and slot_wr_n through 2-flop synchronisers; all decode uses the synchronised copies.
REQ-015 SHALL detect an access on the first clk where synchronised iorq_n=0 and (rd_n=0 or wr_n=0), and the previous cycle did not meet that condition.
REQ-016 SHALL accept a detected access only if slot_a[7:2]==IO_BASE[7:2]; otherwise it is ignored with no outputs changing.
REQ-017 SHALL capture slot_a[1:0], slot_d_in and the write flag at the accept cycle; write takes priority if rd and wr are both low.
REQ-018 SHALL implement FSM states IDLE, REQ, RDWAIT and HOLD.
REQ-019 IDLE SHALL go to REQ on accept, asserting bus_valid on the next cycle.
REQ-020 REQ SHALL hold bus_valid, bus_address, bus_write and bus_wdata stable until the cycle bus_ready=1, then drop bus_valid next cycle; writes go to HOLD, reads go to RDWAIT.
REQ-021 RDWAIT SHALL latch bus_rdata into slot_d_out on bus_rdata_en=1, set slot_data_dir=1 and go to HOLD; a bus_rdata_en arriving in the same cycle as bus_ready SHALL be honoured.
REQ-022 HOLD SHALL stay until synchronised iorq_n=1, then clear slot_data_dir and return to IDLE.
REQ-023 slot_d_out SHALL keep its last value when not driven.
REQ-024 bus_valid SHALL assert exactly once per accepted access; there are no retries and no duplicates.
REQ-025 slot_wait SHALL be asserted when init_busy=1, or combinationally from the accept cycle until the REQ write handshake or the RDWAIT data latch completes.
REQ-026 An access accepted while not in IDLE SHALL be handled per REQ-034.

Reset
REQ-027 reset_n=0 SHALL immediately force: state IDLE, bus_valid=0, bus_write=0, bus_address=0, bus_wdata=0, slot_d_out=0, slot_data_dir=0, overrun=0, and synchronisers to 1 (inactive).
REQ-028 slot_wait during reset SHALL equal init_busy.
REQ-029 A reset mid-transaction SHALL abandon the access without emitting a further bus_valid after release.

Configuration
REQ-030 SHALL use macro MSX_SLOT_WAIT_EN.
REQ-031 With MSX_SLOT_WAIT_EN defined, slot_wait SHALL behave per REQ-025.
REQ-032 With MSX_SLOT_WAIT_EN undefined, slot_wait SHALL be init_busy only.
REQ-033 With the macro defined, an access detected outside IDLE SHALL not occur, because the host is stalled.
REQ-034 With the macro undefined, an access detected outside IDLE SHALL be dropped and overrun SHALL pulse for 1 cycle.

Structure
REQ-035 SHALL put the FSM state enum and the IO port offsets (0: VRAM data, 1: control, 2: palette, 3: indirect register) in shared package msx_slot_pkg.
REQ-036 SHALL contain one sub-module, msx_sync2, a 2-flop synchroniser with reset value 1, instantiated three times.

Verification
REQ-037 Write port 0x89, data 0x06, bus_ready tied 1 -> one bus_valid, bus_address=1, bus_write=1, bus_wdata=0x06.
REQ-038 Write port 0x98, data 0x55 -> no bus_valid, slot_wait stays 0.
REQ-039 Read port 0x88, core returns 0x5A 3 cycles after ready -> slot_d_out=0x5A, slot_data_dir=1 until iorq_n rises, then 0.
REQ-040 Write port 0x8A with bus_ready held 0 for 20 cycles -> slot_wait high throughout (macro defined), exactly one bus_valid handshake.
REQ-041 init_busy=1 at and after reset -> slot_wait=1; init_busy falls -> slot_wait=0 next evaluation.
REQ-042 Assert reset_n=0 while in REQ -> all outputs at reset values immediately; after release, no bus_valid. Also: macro undefined, second write arrives while REQ stalled -> overrun pulses 1 cycle, only the first write is issued.
